// File: rtl/led_matrix_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_matrix_driver_pkg                                                |
// | Shared matrix geometry, scan FSM states and a one-hot helper.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led_matrix_driver_pkg;

  localparam int MATRIX_DIM = 8;
  localparam int ROW_W      = 3;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef logic [MATRIX_DIM-1:0] pixel_row_t;

  function automatic pixel_row_t row_onehot(input logic [ROW_W-1:0] row);
    pixel_row_t v;
    v      = '0;
    v[row] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_row_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_row_scanner                                                      |
// | BLANK/DRIVE row scan sequencer with dwell/blank counters and         |
// | end-of-frame pulse.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_row_scanner
  import led_matrix_driver_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROW_W-1:0] row_o,
  output logic             drive_o,
  output logic             drive_start_o,
  output logic             frame_done_o
);

  localparam int DW_W = $clog2(DWELL_CYCLES) + 1;
  localparam int BL_W = $clog2(BLANK_CYCLES) + 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0]  BLANK_LAST = BL_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(MATRIX_DIM - 1);

  scan_state_e      state_q, state_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [BL_W-1:0]  blank_q, blank_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
      dwell_q <= '0;
      blank_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      row_q   <= row_d;
    end
  end

  // Each counter only runs in its own state and is held at zero otherwise,
  // so it never counts past its terminal value.
  always_comb begin
    state_d       = state_q;
    dwell_d       = '0;
    blank_d       = '0;
    row_d         = row_q;
    drive_start_o = 1'b0;
    frame_done_o  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (blank_q == BLANK_LAST) begin
          state_d       = ST_DRIVE;
          drive_start_o = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          state_d      = ST_BLANK;
          row_d        = row_q + 1'b1;
          frame_done_o = (row_q == ROW_LAST);
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  assign row_o   = row_q;
  assign drive_o = (state_q == ST_DRIVE);

endmodule
`default_nettype wire

// File: rtl/led_matrix_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_matrix_driver                                                    |
// | 8x8 LED matrix framebuffer with CPU write/readback and row scan.     |
// | Optional macro FB_DOUBLE_BUFFER_EN: front/back buffers with swap.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_matrix_driver
  import led_matrix_driver_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [MATRIX_DIM-1:0] wr_data,
  input  logic [ROW_W-1:0]      rd_row,
  output logic [MATRIX_DIM-1:0] rd_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_done,
  output logic [MATRIX_DIM-1:0] led_row,
  output logic [MATRIX_DIM-1:0] led_col
);

  logic [ROW_W-1:0] scan_row;
  logic             scan_drive;
  logic             scan_start;
  logic             scan_frame_done;

  led_row_scanner #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scanner (
    .clk           (clk),
    .reset         (reset),
    .row_o         (scan_row),
    .drive_o       (scan_drive),
    .drive_start_o (scan_start),
    .frame_done_o  (scan_frame_done)
  );

  pixel_row_t col_q;
  pixel_row_t rd_data_q;

`ifdef FB_DOUBLE_BUFFER_EN
  pixel_row_t fb0_q [MATRIX_DIM];
  pixel_row_t fb1_q [MATRIX_DIM];
  logic       front_q;
  logic       pending_q;
  logic       swap_now;

  // front_q selects the displayed buffer; the other one is the CPU's.
  assign swap_now = scan_frame_done & pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MATRIX_DIM; i++) begin
        fb0_q[i] <= '0;
        fb1_q[i] <= '0;
      end
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      rd_data_q <= '0;
      col_q     <= '0;
    end else begin
      if (wr_en) begin
        if (front_q) fb0_q[wr_row] <= wr_data;
        else         fb1_q[wr_row] <= wr_data;
      end
      rd_data_q <= front_q ? fb0_q[rd_row] : fb1_q[rd_row];
      if (scan_start) begin
        col_q <= front_q ? fb1_q[scan_row] : fb0_q[scan_row];
      end
      // A request arriving on the swap cycle itself is held for the next frame.
      if (swap_now) begin
        front_q   <= ~front_q;
        pending_q <= swap_req;
      end else if (swap_req) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign swap_ack = swap_now;
`else
  pixel_row_t fb_q [MATRIX_DIM];
  logic       unused_swap_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MATRIX_DIM; i++) begin
        fb_q[i] <= '0;
      end
      rd_data_q <= '0;
      col_q     <= '0;
    end else begin
      if (wr_en) begin
        fb_q[wr_row] <= wr_data;
      end
      rd_data_q <= fb_q[rd_row];
      if (scan_start) begin
        col_q <= fb_q[scan_row];
      end
    end
  end

  assign unused_swap_req = swap_req;
  assign swap_ack        = 1'b0;
`endif

  assign rd_data    = rd_data_q;
  assign frame_done = scan_frame_done;
  assign led_row    = scan_drive ? row_onehot(scan_row) : '0;
  assign led_col    = scan_drive ? col_q : '0;

endmodule
`default_nettype wire
